// File: rtl/add_op_seq.sv
// add_op_seq: operand sequencer for an external combinational N-bit adder.
// An accepted operand pair is registered onto a_o/b_o. The adder output is
// sampled after SETTLE cycles and the result is then held until the consumer
// takes it. Operations never overlap.
// Optional feature: define ADD_OP_SEQ_CARRY_CNT_EN to add an 8-bit
// saturating count of handed-off results that carried out (carry_cnt).
module add_op_seq #(
  parameter int N      = 5,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic [N-1:0] a_o,
  output logic [N-1:0] b_o,
  input  logic [N-1:0] sum_i,
  input  logic         cout_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum_o,
  output logic         cout_o
`ifdef ADD_OP_SEQ_CARRY_CNT_EN
  ,
  output logic [7:0]   carry_cnt
`endif
);

  // The settle counter only has to reach SETTLE-1. It is cleared on every
  // acceptance, so a wrap after the capture cycle does no harm.
  localparam int            CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          capture;
  logic          handshake;

  // Next-state logic and the handshake/strobe decode for the datapath.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    handshake = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt == CNT_LAST) begin
          capture   = 1'b1;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          handshake = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      // The unused encoding falls back to IDLE.
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is written with non-blocking assignments, so
    // every register samples pre-edge values regardless of block order.
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Settle counter: cleared on acceptance, counts up while settling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (accept)             cnt <= '0;
    else if (state == ST_SETTLE) cnt <= cnt + CW'(1);
  end

  // Operand registers feed the adder and hold until the next acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_o <= '0;
      b_o <= '0;
    end else if (accept) begin
      a_o <= in_a;
      b_o <= in_b;
    end
  end

  // Result registers sample the adder once the settle time has elapsed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_o  <= '0;
      cout_o <= 1'b0;
    end else if (capture) begin
      sum_o  <= sum_i;
      cout_o <= cout_i;
    end
  end

`ifdef ADD_OP_SEQ_CARRY_CNT_EN
  // Saturating count of handed-off results whose carry-out was set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    carry_cnt <= 8'd0;
    else if (handshake && cout_o && carry_cnt != 8'hFF) carry_cnt <= carry_cnt + 8'd1;
  end
`endif

endmodule

// File: doc/add_op_seq.md
ADD_OP_SEQ -- requirements
Module: add_op_seq

Interface
- REQ-001 Parameter N, 5, operand/sum width in bits (N >= 1).
- REQ-002 Parameter SETTLE, 1, cycles operands are held on the adder before result capture (SETTLE >= 1).
- REQ-003 clk  input  1  single clock; all state on rising edge.
- REQ-004 rst_n  input  1  asynchronous, active-low reset.
- REQ-005 in_valid  input  1  operand pair on in_a/in_b is valid.
- REQ-006 in_ready  output  1  block accepts an operand pair this cycle.
- REQ-007 in_a, in_b  input  N  operands.
- REQ-008 a_o, b_o  output  N  registered operands driven to the downstream fullAdderN a/b ports.
- REQ-009 sum_i  input  N, cout_i  input  1  combinational sum/carry returned from fullAdderN.
- REQ-010 out_valid  output  1  captured result is valid.
- REQ-011 out_ready  input  1  consumer takes the result this cycle.
- REQ-012 sum_o  output  N, cout_o  output  1  registered result.

Function
- REQ-013 FSM states: IDLE, SETTLE, HOLD; only IDLE, SETTLE and HOLD are reachable.
- REQ-014 in_ready SHALL be 1 in IDLE only and 0 in SETTLE and HOLD; in_valid outside IDLE is ignored.
- REQ-015 IDLE with in_valid=1: latch in_a/in_b into a_o/b_o, clear settle counter, go to SETTLE.
- REQ-016 SETTLE: counter increments each cycle; when counter == SETTLE-1, capture sum_i->sum_o and cout_i->cout_o, go to HOLD.
- REQ-017 Latency: accept at edge k; capture at edge k+SETTLE; out_valid is 1 from edge k+SETTLE.
- REQ-018 HOLD: out_valid=1; sum_o/cout_o stable; out_ready=1 returns to IDLE at that edge; out_ready=0 stays in HOLD indefinitely.
- REQ-019 a_o/b_o SHALL hold their value from acceptance until the next acceptance, including across HOLD and IDLE.
- REQ-020 No overlap: next operand pair is accepted no earlier than the cycle after the handshake completes; minimum period is SETTLE+2 cycles.
- REQ-021 Sum width is exactly N bits; the carry beyond bit N-1 appears only on cout_o; no truncation or sign extension.

Reset
- REQ-022 rst_n=0 SHALL asynchronously force IDLE, counter=0, a_o=b_o=0, sum_o=0, cout_o=0, out_valid=0, and in_ready=1 once rst_n=1.
- REQ-023 Reset asserted during SETTLE or HOLD discards the in-flight operation; no out_valid is produced for it after release.
- REQ-024 Release of rst_n is synchronous to clk; the first acceptance is possible at the first rising edge after release.

Configuration
- REQ-025 Macro ADD_OP_SEQ_CARRY_CNT_EN defined: adds output carry_cnt (8 bits), incremented at each HOLD->IDLE handshake where cout_o=1, saturating at 255, cleared by reset.
- REQ-026 Macro undefined: the carry_cnt port and counter SHALL be absent; all other behaviour is identical.

Verification (N=5, SETTLE=1 unless stated)
- REQ-027 in_a=00111, in_b=01011, in_valid for 1 cycle, out_ready=1 -> out_valid 1 cycle after acceptance with sum_o=10010, cout_o=0; back in IDLE next cycle.
- REQ-028 in_a=01111, in_b=11011 -> sum_o=01010, cout_o=1; with the macro, carry_cnt goes from 0 to 1 at the handshake.
- REQ-029 Backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid, sum_o, cout_o and a_o/b_o are stable; in_ready=0; a new in_valid is ignored.
- REQ-030 SETTLE=3, in_a=11111, in_b=00001 -> capture exactly 3 edges after acceptance; sum_o=00000, cout_o=1.
- REQ-031 rst_n pulsed low during SETTLE -> outputs zero immediately; no out_valid afterwards; next operand pair is processed normally.
- REQ-032 Macro defined, 260 operations each with cout=1 -> carry_cnt saturates at 255.
